// File: rtl/icache_status_alloc.sv
// Write-side controller for the I-cache per-way status SRAM ({dirty, valid}, 4 ways).
// A line fill reads the set, picks a victim way and writes it valid/clean.
// A flush command walks every {index, way} and clears it.
module icache_status_alloc #(
  parameter int aw  = 4,
  parameter int num = (1 << aw)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_req,
  input  logic [aw-1:0] fill_index,
  output logic          fill_ack,
  output logic [1:0]    fill_way,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  output logic [aw-1:0] sram_index,
  output logic [1:0]    sram_way,
  output logic [1:0]    sram_din,
  output logic          sram_we,
  output logic          sram_en,
  input  logic [1:0]    sram_dout0,
  input  logic [1:0]    sram_dout1,
  input  logic [1:0]    sram_dout2,
  input  logic [1:0]    sram_dout3
);

  typedef enum logic [2:0] {
    IDLE,
    FILL_RD,
    FILL_WR,
    FLUSH,
    FLUSH_DONE
  } state_t;

  // Last {index, way} position of the flush walk.
  localparam logic [aw+1:0] CNT_LAST = (aw + 2)'(4 * num - 1);

  state_t        state_q, state_d;
  logic [aw-1:0] idx_q, idx_d;
  logic [1:0]    victim_q, victim_d;
  logic          from_rr_q, from_rr_d;
  logic [1:0]    rr_q, rr_d;
  logic [aw+1:0] cnt_q, cnt_d;

  // Dirty bits are irrelevant to victim selection.
  logic unused_dirty;
  assign unused_dirty = ^{sram_dout0[1], sram_dout1[1], sram_dout2[1], sram_dout3[1]};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      victim_q  <= '0;
      from_rr_q <= 1'b0;
      rr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      victim_q  <= victim_d;
      from_rr_q <= from_rr_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and Moore outputs; every output is zero in IDLE.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    victim_d   = victim_q;
    from_rr_d  = from_rr_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    fill_ack   = 1'b0;
    fill_way   = '0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    sram_index = '0;
    sram_way   = '0;
    sram_din   = '0;
    sram_we    = 1'b0;
    sram_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end else if (fill_req) begin
          idx_d   = fill_index;
          state_d = FILL_RD;
        end
      end

      FILL_RD: begin
        sram_en    = 1'b1;
        sram_index = idx_q;
        from_rr_d  = 1'b0;
        if (!sram_dout0[0]) begin
          victim_d = 2'd0;
        end else if (!sram_dout1[0]) begin
          victim_d = 2'd1;
        end else if (!sram_dout2[0]) begin
          victim_d = 2'd2;
        end else if (!sram_dout3[0]) begin
          victim_d = 2'd3;
        end else begin
          victim_d  = rr_q;
          from_rr_d = 1'b1;
        end
        state_d = FILL_WR;
      end

      FILL_WR: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_index = idx_q;
        sram_way   = victim_q;
        sram_din   = 2'b01;
        fill_ack   = 1'b1;
        fill_way   = victim_q;
        // Round-robin pointer only advances when it actually chose the victim.
        if (from_rr_q) begin
          rr_d = rr_q + 2'd1;
        end
        state_d = IDLE;
      end

      FLUSH: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        flush_busy = 1'b1;
        sram_index = cnt_q[aw+1:2];
        sram_way   = cnt_q[1:0];
        sram_din   = 2'b00;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FLUSH_DONE;
        end
      end

      FLUSH_DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_status_alloc.sv
// Bench for icache_status_alloc: behavioural status RAM, a transaction-level
// reference model predicting outputs per cycle, directed and random stimulus.
module tb_icache_status_alloc;

  localparam int AW   = 4;
  localparam int NUM  = 16;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst;
  logic          fill_req;
  logic [AW-1:0] fill_index;
  logic          fill_ack;
  logic [1:0]    fill_way;
  logic          flush_req;
  logic          flush_busy;
  logic          flush_done;
  logic [AW-1:0] sram_index;
  logic [1:0]    sram_way;
  logic [1:0]    sram_din;
  logic          sram_we;
  logic          sram_en;
  logic [1:0]    sram_dout0, sram_dout1, sram_dout2, sram_dout3;

  always #5 clk = ~clk;

  icache_status_alloc #(.aw(AW), .num(NUM)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_index(fill_index),
    .fill_ack(fill_ack), .fill_way(fill_way),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .sram_index(sram_index), .sram_way(sram_way), .sram_din(sram_din),
    .sram_we(sram_we), .sram_en(sram_en),
    .sram_dout0(sram_dout0), .sram_dout1(sram_dout1),
    .sram_dout2(sram_dout2), .sram_dout3(sram_dout3)
  );

  // Behavioural status RAM: combinational read, write on posedge.
  bit [1:0] mem     [4][NUM];
  bit [1:0] ref_mem [4][NUM];

  assign sram_dout0 = mem[0][sram_index];
  assign sram_dout1 = mem[1][sram_index];
  assign sram_dout2 = mem[2][sram_index];
  assign sram_dout3 = mem[3][sram_index];

  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_way][sram_index] <= sram_din;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Expected outputs per cycle, filled in ahead of time by the model.
  typedef struct packed {
    bit          ack;
    bit [1:0]    fway;
    bit          busy;
    bit          done;
    bit          we;
    bit          en;
    bit [AW-1:0] idx;
    bit [1:0]    sway;
    bit [1:0]    din;
  } outs_t;

  outs_t exp_q [MAXC];
  int    cyc     = 0;
  int    free_at = 0;
  int    rr_m    = 0;

  // Reference model and per-cycle compare, run on the falling edge.
  always @(negedge clk) begin
    outs_t act;
    outs_t e;
    int    v;
    cyc++;
    if (cyc < MAXC - 80) begin
      act.ack  = fill_ack;   act.fway = fill_way;
      act.busy = flush_busy; act.done = flush_done;
      act.we   = sram_we;    act.en   = sram_en;
      act.idx  = sram_index; act.sway = sram_way;
      act.din  = sram_din;
      tests++;
      if (act != exp_q[cyc]) begin
        fails++;
        $display("FAIL outs cycle %0d: got %h expected %h", cyc, act, exp_q[cyc]);
      end
      if (exp_q[cyc].we) ref_mem[exp_q[cyc].sway][exp_q[cyc].idx] = exp_q[cyc].din;

      if (rst) begin
        for (int k = 1; k <= 70; k++) exp_q[cyc + k] = '0;
        rr_m    = 0;
        free_at = cyc + 1;
      end else if (cyc >= free_at) begin
        if (flush_req) begin
          for (int k = 0; k < 4 * NUM; k++) begin
            e = '0;
            e.busy = 1'b1; e.we = 1'b1; e.en = 1'b1;
            e.idx  = AW'(k / 4);
            e.sway = 2'(k % 4);
            exp_q[cyc + 1 + k] = e;
          end
          e = '0;
          e.done = 1'b1;
          exp_q[cyc + 4 * NUM + 1] = e;
          free_at = cyc + 4 * NUM + 2;
        end else if (fill_req) begin
          v = -1;
          for (int w = 3; w >= 0; w--) if (ref_mem[w][fill_index][0] == 1'b0) v = w;
          if (v < 0) begin
            v    = rr_m;
            rr_m = (rr_m + 1) % 4;
          end
          e = '0;
          e.en = 1'b1; e.idx = fill_index;
          exp_q[cyc + 1] = e;
          e.ack = 1'b1; e.fway = 2'(v); e.we = 1'b1; e.sway = 2'(v); e.din = 2'b01;
          exp_q[cyc + 2] = e;
          free_at = cyc + 3;
        end
      end
    end
  end

  task automatic do_fill(input int idx, output int w, output int lat);
    @(posedge clk); #1;
    fill_req   = 1'b1;
    fill_index = AW'(idx);
    lat = 0;
    w   = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      lat++;
      if (fill_ack) begin
        w = int'(fill_way);
        break;
      end
    end
    fill_req = 1'b0;
    if (w < 0) chk("fill_timeout", 0, 1);
  endtask

  task automatic do_flush(output int busy_n, output int we_n, output int done_n);
    busy_n = 0; we_n = 0; done_n = 0;
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    for (int k = 0; k < 80; k++) begin
      busy_n += int'(flush_busy);
      we_n   += int'(sram_we);
      done_n += int'(flush_done);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int w, lat, b, wn, dn, nz, t_done, t_ack;
    int seq [7] = '{0, 1, 2, 3, 0, 1, 2};
    rst = 1'b1; fill_req = 1'b0; flush_req = 1'b0; fill_index = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", int'({fill_ack, fill_way, flush_busy, flush_done, sram_we,
                            sram_en, sram_index, sram_way, sram_din}), 0);

    for (int i = 0; i < 7; i++) begin
      do_fill(5, w, lat);
      chk("fill5_way", w, seq[i]);
      chk("fill5_lat", lat, 2);
      if (i == 0) begin
        @(posedge clk); #1;
        chk("mem0_5", int'(mem[0][5]), 1);
      end
    end

    mem[0][9] = 2'b01; mem[2][9] = 2'b01;
    ref_mem[0][9] = 2'b01; ref_mem[2][9] = 2'b01;
    do_fill(9, w, lat);
    chk("fill9_way", w, 1);
    do_fill(5, w, lat);
    chk("fill5_rr3", w, 3);

    do_flush(b, wn, dn);
    chk("flush_busy_n", b, 64);
    chk("flush_we_n", wn, 64);
    chk("flush_done_n", dn, 1);
    nz = 0;
    for (int x = 0; x < 4; x++) for (int y = 0; y < NUM; y++) nz += (mem[x][y] != 0) ? 1 : 0;
    chk("flush_clear", nz, 0);

    // Flush and fill in the same IDLE cycle.
    @(posedge clk); #1;
    flush_req = 1'b1; fill_req = 1'b1; fill_index = 4'd3;
    @(posedge clk); #1 flush_req = 1'b0;
    t_done = -100; t_ack = -1; w = -1;
    for (int k = 0; k < 120; k++) begin
      if (flush_done) t_done = k;
      if (fill_ack) begin
        t_ack = k; w = int'(fill_way);
        break;
      end
      @(posedge clk); #1;
    end
    fill_req = 1'b0;
    chk("flushfill_gap", t_ack - t_done, 3);
    chk("flushfill_way", w, 0);

    // Reset on the 10th flush cycle.
    @(posedge clk); #1 flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("busy_before_rst", int'(flush_busy), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_outs", int'({fill_ack, fill_way, flush_busy, flush_done, sram_we,
                          sram_en, sram_index, sram_way, sram_din}), 0);
    dn = 0;
    for (int k = 0; k < 80; k++) begin
      dn += int'(flush_done);
      @(posedge clk); #1;
    end
    chk("rst_no_done", dn, 0);
    do_flush(b, wn, dn);
    chk("reflush_busy_n", b, 64);
    chk("reflush_done_n", dn, 1);

    // Random traffic, compared every cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      flush_req = 1'b0;
      if (fill_ack) fill_req = 1'b0;
      else if (!fill_req && $urandom_range(0, 3) == 0) begin
        fill_req   = 1'b1;
        fill_index = AW'($urandom_range(0, NUM - 1));
      end
      if ($urandom_range(0, 99) == 0) flush_req = 1'b1;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; flush_req = 1'b0; fill_req = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    nz = 0;
    for (int x = 0; x < 4; x++) for (int y = 0; y < NUM; y++) nz += (mem[x][y] != ref_mem[x][y]) ? 1 : 0;
    chk("ram_vs_model", nz, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
